// File: rtl/draw_arbiter.sv
// draw_arbiter: round-robin arbiter that lets three sprite owners (left
// paddle, right paddle, ball) share one box-fill drawer. Each service first
// erases the requester's previously drawn box (if any) with BG_COLOR, then
// draws the new box, then pulses req_ready for one cycle.
//
// Ports:
//   clock, reset_n        single clock, synchronous active-low reset
//   req_valid/req_ready   per-requester request / one-cycle completion pulse
//   req_x/req_y/req_color packed 9/9/3-bit fields, slice i owned by requester i
//   d_valid/d_ready       drawer command handshake
//   d_x/d_y/d_w/d_h       box origin and size; zero when d_valid=0
//   d_color               box fill colour; zero when d_valid=0
//   d_done                drawer finished the accepted box
//   grant                 one-hot requester in service, 0 when idle

// Remembers where one requester's box was last drawn so it can be erased.
module draw_arbiter_slot (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       upd_i,
    input  logic [8:0] x_i,
    input  logic [8:0] y_i,
    output logic       have_o,
    output logic [8:0] x_o,
    output logic [8:0] y_o
);
    logic       have_q;
    logic [8:0] x_q;
    logic [8:0] y_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            have_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
        end else if (upd_i) begin
            have_q <= 1'b1;
            x_q    <= x_i;
            y_q    <= y_i;
        end
    end

    assign have_o = have_q;
    assign x_o    = x_q;
    assign y_o    = y_q;
endmodule

module draw_arbiter #(
    parameter int         NUM_REQ  = 3,
    parameter logic [8:0] PADDLE_W = 9'd10,
    parameter logic [8:0] PADDLE_H = 9'd48,
    parameter logic [8:0] BALL_W   = 9'd4,
    parameter logic [8:0] BALL_H   = 9'd4,
    parameter logic [2:0] BG_COLOR = 3'b000
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [9*NUM_REQ-1:0] req_x,
    input  logic [9*NUM_REQ-1:0] req_y,
    input  logic [3*NUM_REQ-1:0] req_color,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic [8:0]           d_x,
    output logic [8:0]           d_y,
    output logic [8:0]           d_w,
    output logic [8:0]           d_h,
    output logic [2:0]           d_color,
    input  logic                 d_done,
    output logic [NUM_REQ-1:0]   grant
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IW-1:0] idx_t;
    // The highest index is the ball; all others are paddles.
    localparam idx_t BALL_IDX = idx_t'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_ISSUE,
        S_ERASE_WAIT,
        S_DRAW_ISSUE,
        S_DRAW_WAIT,
        S_ACK
    } state_t;

    state_t               state_q, state_d;
    idx_t                 idx_q, idx_d;
    idx_t                 rr_q, rr_d;
    logic [8:0]           x_q, x_d;
    logic [8:0]           y_q, y_d;
    logic [2:0]           col_q, col_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;

    logic [NUM_REQ-1:0][8:0] rx, ry;
    logic [NUM_REQ-1:0][2:0] rc;
    logic [NUM_REQ-1:0]      have_prev;
    logic [NUM_REQ-1:0][8:0] prev_x, prev_y;

    logic       sel_found;
    idx_t       sel_idx;
    idx_t       cand;
    logic [8:0] box_w, box_h;

    assign rx = req_x;
    assign ry = req_y;
    assign rc = req_color;

    // Position history, one slot per requester, updated as the ack retires.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
        draw_arbiter_slot u_slot (
            .clock   (clock),
            .reset_n (reset_n),
            .upd_i   ((state_q == S_ACK) && (idx_q == idx_t'(i))),
            .x_i     (x_q),
            .y_i     (y_q),
            .have_o  (have_prev[i]),
            .x_o     (prev_x[i]),
            .y_o     (prev_y[i])
        );
    end

    // Round-robin pick: scan from the far end back toward rr_q so the
    // candidate closest to rr_q is the one left standing.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = idx_t'((int'(rr_q) + k) % NUM_REQ);
            if (req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        x_d     = x_q;
        y_d     = y_q;
        col_d   = col_q;
        grant_d = grant_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    // Latch the request so later input changes cannot
                    // disturb the box in flight.
                    idx_d            = sel_idx;
                    x_d              = rx[sel_idx];
                    y_d              = ry[sel_idx];
                    col_d            = rc[sel_idx];
                    grant_d          = '0;
                    grant_d[sel_idx] = 1'b1;
                    state_d          = have_prev[sel_idx] ? S_ERASE_ISSUE : S_DRAW_ISSUE;
                end
            end
            S_ERASE_ISSUE: if (d_ready) state_d = S_ERASE_WAIT;
            S_ERASE_WAIT:  if (d_done)  state_d = S_DRAW_ISSUE;
            S_DRAW_ISSUE:  if (d_ready) state_d = S_DRAW_WAIT;
            S_DRAW_WAIT:   if (d_done)  state_d = S_ACK;
            S_ACK: begin
                grant_d = '0;
                rr_d    = (idx_q == BALL_IDX) ? '0 : idx_t'(idx_q + 1'b1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rr_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            col_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
            x_q     <= x_d;
            y_q     <= y_d;
            col_q   <= col_d;
            grant_q <= grant_d;
        end
    end

    assign box_w = (idx_q == BALL_IDX) ? BALL_W : PADDLE_W;
    assign box_h = (idx_q == BALL_IDX) ? BALL_H : PADDLE_H;

    // Drawer command is a pure function of registered state, so it holds
    // steady for as long as the drawer stalls.
    always_comb begin
        d_valid = 1'b0;
        d_x     = '0;
        d_y     = '0;
        d_w     = '0;
        d_h     = '0;
        d_color = '0;
        case (state_q)
            S_ERASE_ISSUE: begin
                d_valid = 1'b1;
                d_x     = prev_x[idx_q];
                d_y     = prev_y[idx_q];
                d_w     = box_w;
                d_h     = box_h;
                d_color = BG_COLOR;
            end
            S_DRAW_ISSUE: begin
                d_valid = 1'b1;
                d_x     = x_q;
                d_y     = y_q;
                d_w     = box_w;
                d_h     = box_h;
                d_color = col_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == S_ACK) req_ready[idx_q] = 1'b1;
    end

    assign grant = grant_q;
endmodule
